// File: rtl/mem_arb_rr4.sv
// Four-port round-robin arbiter in front of a single 32-bit memory master port.
// A stalled transfer is force-completed with all-ones read data after TIMEOUT cycles.
module mem_arb_rr4 #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_addr,
  input  logic [127:0] req_wdata,
  input  logic [15:0]  req_wstrb,
  output logic [31:0]  req_rdata,
  output logic         mem_valid,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_wstrb,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata,
  output logic [3:0]   grant,
  output logic         timeout,
  output logic [7:0]   timeout_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [3:0]  grant_q;
  logic [15:0] wait_cnt;
  logic [7:0]  to_cnt;

  logic        busy;
  logic        done_forced;
  logic        done;
  logic [3:0]  arb_mask;
  logic        arb_found;
  logic [1:0]  arb_idx;
  logic [1:0]  cand;
  logic [1:0]  sel;

  assign busy        = (state == BUSY);
  assign done_forced = busy && !mem_ready && (wait_cnt == LIMIT);
  assign done        = (busy && mem_ready) || done_forced;

  // While busy, ptr equals the granted port, so it also serves as the slice select.
  assign arb_mask = busy ? (req_valid & ~grant_q) : req_valid;
  assign sel      = busy ? ptr : 2'd0;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    cand      = ptr;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!arb_found && arb_mask[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign mem_valid     = busy;
  assign mem_addr      = req_addr[{sel, 5'd0} +: 32];
  assign mem_wdata     = req_wdata[{sel, 5'd0} +: 32];
  assign mem_wstrb     = req_wstrb[{sel, 2'd0} +: 4];
  assign grant         = grant_q;
  assign req_ready     = (done && !rst) ? grant_q : 4'b0000;
  assign req_rdata     = done_forced ? 32'hFFFF_FFFF : mem_rdata;
  assign timeout       = done_forced && !rst;
  assign timeout_count = to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      grant_q  <= 4'b0000;
      wait_cnt <= 16'd0;
      to_cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            state    <= BUSY;
            ptr      <= arb_idx;
            grant_q  <= 4'b0001 << arb_idx;
            wait_cnt <= 16'd0;
          end
        end
        BUSY: begin
          if (done) begin
            if (done_forced && to_cnt != 8'hFF)
              to_cnt <= to_cnt + 8'd1;
            // Hand over directly to the next winner so the master port never idles.
            if (arb_found) begin
              ptr      <= arb_idx;
              grant_q  <= 4'b0001 << arb_idx;
              wait_cnt <= 16'd0;
            end else begin
              state   <= IDLE;
              grant_q <= 4'b0000;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb_rr4.sv
// Directed bench for mem_arb_rr4 with TIMEOUT=4: reset, single read, fairness,
// timeout, limit race, reset mid-transfer and timeout counter saturation.
module tb_mem_arb_rr4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [15:0]  req_wstrb;
  logic [31:0]  req_rdata;
  logic         mem_valid;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [3:0]   grant;
  logic         timeout;
  logic [7:0]   timeout_count;

  int total = 0;
  int bad   = 0;

  mem_arb_rr4 #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .timeout(timeout), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  // Inputs change at the falling edge; returning leaves reset released before the next rise.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; req_valid = 4'b1111;
    @(negedge clk); #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_valid got=%b exp=0", mem_valid); end
    total++; if (grant !== 4'b0000) begin bad++; $display("[TB] FAIL reset_grant got=%b exp=0000", grant); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL reset_req_ready got=%b exp=0000", req_ready); end
    total++; if (timeout_count !== 8'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", timeout_count); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout got=%b exp=0", timeout); end
    rst = 1'b0; req_valid = 4'b0; mem_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req_addr[31:0] = 32'h0000_00A0;
    #1;
    total++; if (mem_addr !== 32'h0000_00A0) begin bad++; $display("[TB] FAIL idle_addr got=%h exp=000000a0", mem_addr); end
    req_valid = 4'b0100; req_addr[95:64] = 32'h0000_0100; req_wstrb[11:8] = 4'b0000;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0100) begin bad++; $display("[TB] FAIL single_grant got=%b exp=0100", grant); end
    total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_mem_valid got=%b exp=1", mem_valid); end
    total++; if (mem_addr !== 32'h0000_0100) begin bad++; $display("[TB] FAIL single_addr got=%h exp=00000100", mem_addr); end
    total++; if (mem_wstrb !== 4'b0000) begin bad++; $display("[TB] FAIL single_wstrb got=%b exp=0000", mem_wstrb); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL single_early_ready got=%b exp=0000", req_ready); end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("[TB] FAIL single_ready got=%b exp=0100", req_ready); end
    total++; if (req_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL single_rdata got=%h exp=12345678", req_rdata); end
    @(negedge clk);
    req_valid = 4'b0; mem_ready = 1'b0;
    #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_after got=%b exp=0", mem_valid); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL single_ready_once got=%b exp=0000", req_ready); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_addr[32*i +: 32]  = 32'h0000_1000 + 32'(i);
      req_wdata[32*i +: 32] = 32'hD000_0000 + 32'(i);
      req_wstrb[4*i +: 4]   = 4'(i + 1);
    end
    req_valid = 4'b1111; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      total++; if (grant !== exp_g[n]) begin bad++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", n, grant, exp_g[n]); end
      total++; if (req_ready !== exp_g[n]) begin bad++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", n, req_ready, exp_g[n]); end
      total++; if (mem_valid !== 1'b1) begin bad++; $display("[TB] FAIL rr_no_idle[%0d] got=%b exp=1", n, mem_valid); end
      total++; if (mem_addr !== 32'h0000_1000 + 32'(exp_i[n])) begin bad++; $display("[TB] FAIL rr_addr[%0d] got=%h", n, mem_addr); end
      total++; if (mem_wdata !== 32'hD000_0000 + 32'(exp_i[n])) begin bad++; $display("[TB] FAIL rr_wdata[%0d] got=%h", n, mem_wdata); end
      total++; if (mem_wstrb !== 4'(exp_i[n] + 2'd1) && !(exp_i[n] == 2'd3 && mem_wstrb === 4'd4)) begin bad++; $display("[TB] FAIL rr_wstrb[%0d] got=%b", n, mem_wstrb); end
    end
    req_valid = 4'b0; mem_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int high = 0;
    do_reset();
    req_valid = 4'b0010; mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk); #1;
      if (mem_valid === 1'b1) high++;
      if (n < 4) begin
        total++; if (req_ready !== 4'b0000 || timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_early[%0d] ready=%b timeout=%b exp 0000/0", n, req_ready, timeout); end
      end
    end
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL to_ready got=%b exp=0010", req_ready); end
    total++; if (req_rdata !== 32'hFFFF_FFFF) begin bad++; $display("[TB] FAIL to_rdata got=%h exp=ffffffff", req_rdata); end
    total++; if (timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_pulse got=%b exp=1", timeout); end
    @(negedge clk);
    req_valid = 4'b0;
    #1;
    if (mem_valid === 1'b1) high++;
    total++; if (high != 4) begin bad++; $display("[TB] FAIL to_valid_cycles got=%0d exp=4", high); end
    total++; if (timeout_count !== 8'd1) begin bad++; $display("[TB] FAIL to_count got=%0d exp=1", timeout_count); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL to_pulse_width got=%b exp=0", timeout); end
  endtask

  task automatic test_limit_race();
    do_reset();
    req_valid = 4'b0010; mem_ready = 1'b0;
    repeat (4) @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("[TB] FAIL race_ready got=%b exp=0010", req_ready); end
    total++; if (req_rdata !== 32'hCAFE_F00D) begin bad++; $display("[TB] FAIL race_rdata got=%h exp=cafef00d", req_rdata); end
    total++; if (timeout !== 1'b0) begin bad++; $display("[TB] FAIL race_timeout got=%b exp=0", timeout); end
    @(negedge clk);
    req_valid = 4'b0; mem_ready = 1'b0;
    #1;
    total++; if (timeout_count !== 8'd0) begin bad++; $display("[TB] FAIL race_count got=%0d exp=0", timeout_count); end
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL race_idle got=%b exp=0", mem_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1000;
    @(negedge clk); #1;
    total++; if (grant !== 4'b1000) begin bad++; $display("[TB] FAIL mid_grant got=%b exp=1000", grant); end
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("[TB] FAIL mid_ready_gated got=%b exp=0000", req_ready); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; req_valid = 4'b1001;
    #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_abandon got=%b exp=0", mem_valid); end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("[TB] FAIL mid_regrant got=%b exp=0001", grant); end
    req_valid = 4'b0;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    int cycles = 0;
    do_reset();
    req_valid = 4'b0010; mem_ready = 1'b0;
    while (pulses < 300 && cycles < 3000) begin
      @(negedge clk); #1;
      cycles++;
      if (timeout === 1'b1) pulses++;
      if (pulses == 100 && timeout === 1'b1) begin
        total++; if (timeout_count !== 8'd99) begin bad++; $display("[TB] FAIL sat_mid got=%0d exp=99", timeout_count); end
      end
    end
    total++; if (pulses != 300) begin bad++; $display("[TB] FAIL sat_pulses got=%0d exp=300", pulses); end
    @(negedge clk);
    req_valid = 4'b0;
    #1;
    total++; if (timeout_count !== 8'd255) begin bad++; $display("[TB] FAIL sat_count got=%0d exp=255", timeout_count); end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_limit_race();
    test_reset_mid();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arb_rr4.md
MEM_ARB_RR4 -- requirements
Module: mem_arb_rr4

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, range 1..65535: max cycles mem_valid is held for one transfer before forced completion.
REQ-002 SHALL have clk, input, 1: clock; all state changes on the rising edge.
REQ-003 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have req_valid, input, 4: per-requester request; requester i uses bit i.
REQ-005 SHALL have req_ready, output, 4: per-requester completion strobe, one cycle.
REQ-006 SHALL have req_addr, input, 128: requester i address in bits [32i+31:32i].
REQ-007 SHALL have req_wdata, input, 128: requester i write data in bits [32i+31:32i].
REQ-008 SHALL have req_wstrb, input, 16: requester i byte strobes in bits [4i+3:4i]; 0 means read.
REQ-009 SHALL have req_rdata, output, 32: read data shared by all requesters, qualified by req_ready.
REQ-010 SHALL have mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0], outputs: master request.
REQ-011 SHALL have mem_ready, mem_rdata[31:0], inputs: master completion and read data.
REQ-012 SHALL have grant, output, 4: one-hot owner of the master port, all-zero when idle.
REQ-013 SHALL have timeout, output, 1: one-cycle pulse on forced completion.
REQ-014 SHALL have timeout_count, output, 8: saturating count of forced completions.

Function
REQ-015 SHALL implement two states: IDLE (grant=0, mem_valid=0) and BUSY (mem_valid=1, grant one-hot).
REQ-016 SHALL hold a 2-bit round-robin pointer ptr; candidate order is ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-017 SHALL, in IDLE with any req_valid high, grant the first valid candidate, set ptr to it, and enter BUSY next edge; mem_valid first asserts the cycle after req_valid is first sampled.
REQ-018 SHALL, in BUSY, drive mem_addr/mem_wdata/mem_wstrb combinationally from the granted slice; in IDLE drive them from requester 0.
REQ-019 SHALL, in BUSY with mem_ready=1, assert req_ready[g] for the granted port g that cycle only; req_rdata=mem_rdata.
REQ-020 SHALL, on that completion, re-arbitrate among valid ports other than g, same candidate order, and enter BUSY on the winner next edge (zero idle cycles), else IDLE.
REQ-021 SHALL keep a 16-bit wait counter, cleared on every grant, incremented each BUSY cycle with mem_ready=0.
REQ-022 SHALL force completion when counter==TIMEOUT-1 and mem_ready=0: req_ready[g]=1, req_rdata=32'hFFFFFFFF, timeout=1, then re-arbitrate per REQ-020.
REQ-023 SHALL give normal completion priority when mem_ready=1 in the limit cycle; no timeout pulse.
REQ-024 SHALL increment timeout_count on each forced completion, saturating at 255.
REQ-025 SHALL assume requesters hold valid, addr, wdata and wstrb stable until their req_ready; behaviour otherwise is undefined.
REQ-026 SHALL never assert more than one req_ready bit, nor any req_ready while mem_valid=0.

Reset
REQ-027 SHALL, with rst high at an edge, set state IDLE, ptr=3, wait counter 0, timeout_count 0.
REQ-028 SHALL gate req_ready and timeout low while rst is high; an in-flight transfer is abandoned and mem_valid is 0 the cycle after.
REQ-029 SHALL give requester 0 highest priority on the first arbitration after reset (ptr=3).

Verification
REQ-030 Single: after reset, req_valid=4'b0100, read addr 0x100, mem_ready 2 cycles later with rdata 0x12345678 -> grant=4'b0100, req_ready[2] one cycle, req_rdata 0x12345678.
REQ-031 Fairness: all four valid continuously, mem_ready=1 every BUSY cycle -> grant order 0,1,2,3,0; back-to-back with no IDLE cycles.
REQ-032 Timeout: TIMEOUT=4, req_valid[1]=1, mem_ready held 0 -> mem_valid high exactly 4 cycles, req_ready[1]=1 with rdata 0xFFFFFFFF, timeout pulse, timeout_count=1.
REQ-033 Limit race: TIMEOUT=4, mem_ready=1 in the 4th BUSY cycle -> normal completion, rdata=mem_rdata, timeout=0, count unchanged.
REQ-034 Reset mid-transfer: rst during BUSY on port 3 -> no req_ready, mem_valid=0 next cycle, next request from ports 0 and 3 grants port 0.
REQ-035 Saturation: 300 forced completions -> timeout_count=255.
